// File: rtl/shift_sequencer.sv
// Multicycle sequencer in front of the combinational shift unit. It splits shift amounts
// of 0-255 into passes of at most MAX_STEP bits and returns the result over a valid/ready handshake.
module shift_sequencer #(
  parameter int unsigned MAX_STEP = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_operand,
  input  logic [31:0] req_amount,
  input  logic [3:0]  req_cmd,
  output logic [31:0] sh_in,
  output logic [31:0] sh_amt,
  output logic [3:0]  sh_cmd,
  input  logic [31:0] sh_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_zero,
  output logic        res_neg,
  output logic        busy
);

  localparam logic [8:0] MaxStep = 9'(MAX_STEP);

  typedef enum logic [1:0] {StIdle, StPass, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [8:0]  remaining_q, remaining_d;

  logic [8:0]  step;
  logic [8:0]  remaining_next;
  logic [8:0]  eff_amt;
  logic [3:0]  eff_cmd;

  // Only the low byte of the amount is architecturally meaningful.
  logic unused_amount;
  assign unused_amount = ^req_amount[31:8];

  // Rotates wrap at 32; unknown commands become a zero-length LSL.
  always_comb begin
    eff_amt = 9'd0;
    eff_cmd = 4'd0;
    case (req_cmd)
      4'd0, 4'd1, 4'd2: begin
        eff_amt = {1'b0, req_amount[7:0]};
        eff_cmd = req_cmd;
      end
      4'd3: begin
        eff_amt = {4'b0000, req_amount[4:0]};
        eff_cmd = req_cmd;
      end
      default: ;
    endcase
  end

  assign step           = (remaining_q > MaxStep) ? MaxStep : remaining_q;
  assign remaining_next = remaining_q - step;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      work_q      <= '0;
      cmd_q       <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cmd_q       <= cmd_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cmd_d       = cmd_q;
    remaining_d = remaining_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          work_d      = req_operand;
          cmd_d       = eff_cmd;
          remaining_d = eff_amt;
          state_d     = StPass;
        end
      end
      StPass: begin
        work_d      = sh_out;
        remaining_d = remaining_next;
        if (remaining_next == 9'd0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    res_valid = 1'b0;
    sh_amt    = 32'd0;
    sh_cmd    = 4'd0;
    case (state_q)
      StIdle: req_ready = 1'b1;
      StPass: begin
        busy   = 1'b1;
        // MAX_STEP never exceeds 31, so the step always fits in five bits.
        sh_amt = {27'd0, step[4:0]};
        sh_cmd = cmd_q;
      end
      StDone: begin
        busy      = 1'b1;
        res_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign sh_in    = work_q;
  assign res_data = work_q;
  assign res_zero = (work_q == 32'd0);
  assign res_neg  = work_q[31];

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer; a behavioural shift unit closes the loop on sh_*.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_operand;
  logic [31:0] req_amount;
  logic [3:0]  req_cmd;
  logic [31:0] sh_in;
  logic [31:0] sh_amt;
  logic [3:0]  sh_cmd;
  logic [31:0] sh_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_zero;
  logic        res_neg;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.MAX_STEP(31)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_operand(req_operand),
    .req_amount (req_amount),
    .req_cmd    (req_cmd),
    .sh_in      (sh_in),
    .sh_amt     (sh_amt),
    .sh_cmd     (sh_cmd),
    .sh_out     (sh_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_zero   (res_zero),
    .res_neg    (res_neg),
    .busy       (busy)
  );

  // Combinational shift unit.
  always_comb begin
    sh_out = sh_in;
    case (sh_cmd)
      4'd0: sh_out = sh_in << sh_amt[4:0];
      4'd1: sh_out = sh_in >> sh_amt[4:0];
      4'd2: sh_out = $signed(sh_in) >>> sh_amt[4:0];
      4'd3: sh_out = (sh_in >> sh_amt[4:0]) | (sh_in << (6'd32 - {1'b0, sh_amt[4:0]}));
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check_eq({tag, "_res_data"}, res_data, 32'd0);
    check_eq({tag, "_res_zero"}, 32'(res_zero), 32'd1);
    check_eq({tag, "_res_neg"}, 32'(res_neg), 32'd0);
    check_eq({tag, "_sh_amt"}, sh_amt, 32'd0);
    check_eq({tag, "_sh_cmd"}, 32'(sh_cmd), 32'd0);
    check_eq({tag, "_sh_in"}, sh_in, 32'd0);
  endtask

  // Issues one request and follows it to DONE; leaves the DUT in DONE.
  task automatic do_op(input string tag, input logic [31:0] op, input logic [31:0] amt,
                       input logic [3:0] cmd, input logic [31:0] exp_data, input int exp_p,
                       input logic [31:0] exp_last, input logic [3:0] exp_shcmd,
                       input logic [31:0] exp_sum);
    int          passes  = 0;
    logic [31:0] last    = 32'd0;
    logic [31:0] sum     = 32'd0;
    logic        full_ok = 1'b1;
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_operand = op;
    req_amount  = amt;
    req_cmd     = cmd;
    tick();
    req_valid   = 1'b0;
    req_operand = ~op;
    req_amount  = 32'd1;
    req_cmd     = 4'd1;
    while (res_valid !== 1'b1 && passes < 20) begin
      check_eq({tag, "_sh_cmd"}, 32'(sh_cmd), 32'(exp_shcmd));
      if (passes > 0 && last !== 32'd31) full_ok = 1'b0;
      last = sh_amt;
      sum  = sum + sh_amt;
      passes++;
      tick();
    end
    check_eq({tag, "_passes"}, 32'(passes), 32'(exp_p));
    check_eq({tag, "_last_amt"}, last, exp_last);
    check_eq({tag, "_amt_sum"}, sum, exp_sum);
    check_eq({tag, "_full_steps"}, 32'(full_ok), 32'd1);
    check_eq({tag, "_res_valid"}, 32'(res_valid), 32'd1);
    check_eq({tag, "_res_data"}, res_data, exp_data);
    check_eq({tag, "_res_zero"}, 32'(res_zero), 32'(exp_data == 32'd0));
    check_eq({tag, "_res_neg"}, 32'(res_neg), 32'(exp_data[31]));
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_done_sh_amt"}, sh_amt, 32'd0);
  endtask

  task automatic check_back_to_idle(input string tag);
    tick();
    check_eq({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_idle_valid"}, 32'(res_valid), 32'd0);
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic seen_valid;
    reset       = 1'b0;
    req_valid   = 1'b0;
    req_operand = 32'hA5A5_A5A5;
    req_amount  = 32'd7;
    req_cmd     = 4'd0;
    res_ready   = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    reset = 1'b1;

    res_ready = 1'b1;
    do_op("lsl3", 32'h8000_000A, 32'd3, 4'd0, 32'h0000_0050, 1, 32'd3, 4'd0, 32'd3);
    check_back_to_idle("lsl3");

    do_op("asr200", 32'h8000_0000, 32'd200, 4'd2, 32'hFFFF_FFFF, 7, 32'd14, 4'd2, 32'd200);
    check_back_to_idle("asr200");

    do_op("lsr255", 32'hFFFF_FFFF, 32'd255, 4'd1, 32'h0000_0000, 9, 32'd7, 4'd1, 32'd255);
    check_back_to_idle("lsr255");

    do_op("ror36", 32'h0000_000F, 32'h0000_0124, 4'd3, 32'hF000_0000, 1, 32'd4, 4'd3, 32'd4);
    check_back_to_idle("ror36");

    do_op("pass", 32'h1234_5678, 32'h0000_0055, 4'd9, 32'h1234_5678, 1, 32'd0, 4'd0, 32'd0);
    check_back_to_idle("pass");

    // Backpressure with a competing request that must not be latched.
    res_ready = 1'b0;
    do_op("bp", 32'h0000_0001, 32'd5, 4'd0, 32'h0000_0020, 1, 32'd5, 4'd0, 32'd5);
    for (int i = 0; i < 5; i++) begin
      req_valid   = 1'b1;
      req_operand = 32'hDEAD_BEEF;
      req_amount  = 32'd0;
      req_cmd     = 4'd0;
      tick();
      check_eq("bp_hold_valid", 32'(res_valid), 32'd1);
      check_eq("bp_hold_data", res_data, 32'h0000_0020);
      check_eq("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    res_ready = 1'b1;
    tick();
    check_eq("bp_nobypass_ready", 32'(req_ready), 32'd1);
    check_eq("bp_nobypass_valid", 32'(res_valid), 32'd0);
    check_eq("bp_nobypass_work", sh_in, 32'h0000_0020);
    req_valid = 1'b0;
    tick();
    check_eq("bp_idle_ready", 32'(req_ready), 32'd1);
    check_eq("bp_idle_work", sh_in, 32'h0000_0020);

    // Reset during the second pass of LSL by 100.
    req_valid   = 1'b1;
    req_operand = 32'h0000_0001;
    req_amount  = 32'd100;
    req_cmd     = 4'd0;
    tick();
    req_valid = 1'b0;
    check_eq("rst_pass1_amt", sh_amt, 32'd31);
    tick();
    check_eq("rst_pass2_amt", sh_amt, 32'd31);
    check_eq("rst_pass2_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_reset_state("rst_mid");
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid !== 1'b0) seen_valid = 1'b1;
    end
    check_eq("rst_no_result", 32'(seen_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
